// File: rtl/bus_rx_fifo.sv
// Receive FIFO behind the bus control FSM: buffers good words, drops words seen
// during errors, counts error events and flags overflow.
module bus_rx_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              error_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       fifo_count,
  output logic              overflow,
  output logic [CNT_W-1:0]  err_count,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACTIVE   = 2'b01,
    ERR_HOLD = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q, count_d;
  logic [DATA_W-1:0]   dout_q;
  logic                dv_q;
  logic                ovf_q;
  logic [CNT_W-1:0]    errc_q;
  logic                err_prev_q;

  logic wr_req, wr_ok, rd_ok, err_evt;

  assign empty  = (count_q == '0);
  assign full   = (count_q == (AW+1)'(DEPTH));
  assign rd_ok  = rd_en & ~empty;
  // A word is a candidate for storage only outside any error condition.
  assign wr_req = valid_in & ~error_in & (state_q != ERR_HOLD);
  assign wr_ok  = wr_req & (~full | rd_ok);
  assign err_evt = error_in & ~err_prev_q;

  always_comb begin
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (error_in)   state_d = ERR_HOLD;
        else if (wr_ok) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (error_in)             state_d = ERR_HOLD;
        else if (count_d == '0)   state_d = IDLE;
      end
      ERR_HOLD: begin
        if (!error_in) state_d = (count_d != '0) ? ACTIVE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dout_q     <= '0;
      dv_q       <= 1'b0;
      ovf_q      <= 1'b0;
      errc_q     <= '0;
      err_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      dv_q       <= rd_ok;
      err_prev_q <= error_in;
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        dout_q   <= mem[rd_ptr_q];
      end
      if (wr_req && full && !rd_ok) ovf_q <= 1'b1;
      if (err_evt && (errc_q != '1)) errc_q <= errc_q + 1'b1;
    end
  end

  // Storage carries no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= data_in;
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign err_count  = errc_q;
  assign state      = state_q;

endmodule

// File: tb/tb_bus_rx_fifo.sv
// Directed bench for bus_rx_fifo: vector table for the main flows, hand-written
// sequences for mid-stream reset and error counter saturation.
module tb_bus_rx_fifo;

  localparam logic [1:0] S_I = 2'b00;
  localparam logic [1:0] S_A = 2'b01;
  localparam logic [1:0] S_E = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic        valid_in, error_in, rd_en;
  logic [15:0] data_out;
  logic        data_valid, empty, full, overflow;
  logic [3:0]  fifo_count;
  logic [7:0]  err_count;
  logic [1:0]  state;

  always #5 clk = ~clk;

  bus_rx_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .error_in   (error_in),
    .rd_en      (rd_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .empty      (empty),
    .full       (full),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .err_count  (err_count),
    .state      (state)
  );

  typedef struct {
    logic        v, e, r;
    logic [15:0] din;
    logic [15:0] dout;
    logic        dv;
    logic [3:0]  cnt;
    logic        ovf;
    logic [7:0]  errc;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] dout, input logic dv,
                           input logic [3:0] cnt, input logic ovf, input logic [7:0] errc,
                           input logic [1:0] st);
    chk({tag, " data_out"},   32'(data_out),   32'(dout));
    chk({tag, " data_valid"}, 32'(data_valid), 32'(dv));
    chk({tag, " fifo_count"}, 32'(fifo_count), 32'(cnt));
    chk({tag, " empty"},      32'(empty),      32'(cnt == 4'd0));
    chk({tag, " full"},       32'(full),       32'(cnt == 4'd8));
    chk({tag, " overflow"},   32'(overflow),   32'(ovf));
    chk({tag, " err_count"},  32'(err_count),  32'(errc));
    chk({tag, " state"},      32'(state),      32'(st));
  endtask

  task automatic add(input logic v, input logic e, input logic r, input logic [15:0] din,
                     input logic [15:0] dout, input logic dv, input logic [3:0] cnt,
                     input logic ovf, input logic [7:0] errc, input logic [1:0] st);
    vec_t t;
    t.v = v; t.e = e; t.r = r; t.din = din; t.dout = dout; t.dv = dv;
    t.cnt = cnt; t.ovf = ovf; t.errc = errc; t.st = st;
    vecs.push_back(t);
  endtask

  task automatic step(input logic v, input logic e, input logic r, input logic [15:0] din);
    valid_in = v; error_in = e; rd_en = r; data_in = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; error_in = 1'b0; rd_en = 1'b0; data_in = '0;
    #2 reset = 1'b0;
    #10;
    check_all("reset", 16'h0000, 1'b0, 4'd0, 1'b0, 8'd0, S_I);
    @(posedge clk);
    #1 reset = 1'b1;

    // push three, pop three, then pop on empty
    add(1,0,0,16'hFBA0, 16'h0000,0,4'd1,0,8'd0,S_A);
    add(1,0,0,16'hF0A1, 16'h0000,0,4'd2,0,8'd0,S_A);
    add(1,0,0,16'hF102, 16'h0000,0,4'd3,0,8'd0,S_A);
    add(0,0,1,16'h0000, 16'hFBA0,1,4'd2,0,8'd0,S_A);
    add(0,0,1,16'h0000, 16'hF0A1,1,4'd1,0,8'd0,S_A);
    add(0,0,1,16'h0000, 16'hF102,1,4'd0,0,8'd0,S_I);
    add(0,0,0,16'h0000, 16'hF102,0,4'd0,0,8'd0,S_I);
    add(0,0,1,16'h0000, 16'hF102,0,4'd0,0,8'd0,S_I);
    // fill, write+read when full, overflow, drain
    for (int k = 0; k < 8; k++)
      add(1,0,0,16'hF000 + 16'(k), 16'hF102,0,4'(k+1),0,8'd0,S_A);
    add(1,0,1,16'hF1F0, 16'hF000,1,4'd8,0,8'd0,S_A);
    add(1,0,0,16'hF008, 16'hF000,0,4'd8,1,8'd0,S_A);
    for (int k = 1; k < 8; k++)
      add(0,0,1,16'h0000, 16'hF000 + 16'(k),1,4'(8-k),1,8'd0,S_A);
    add(0,0,1,16'h0000, 16'hF1F0,1,4'd0,1,8'd0,S_I);
    add(0,0,0,16'h0000, 16'hF1F0,0,4'd0,1,8'd0,S_I);
    // error handling: drops, exit-cycle drop, event counting
    add(1,1,0,16'hA5D3, 16'hF1F0,0,4'd0,1,8'd1,S_E);
    add(1,1,0,16'hFDC9, 16'hF1F0,0,4'd0,1,8'd1,S_E);
    add(1,1,0,16'hFDC9, 16'hF1F0,0,4'd0,1,8'd1,S_E);
    add(1,0,0,16'hBEEF, 16'hF1F0,0,4'd0,1,8'd1,S_I);
    add(0,0,0,16'h0000, 16'hF1F0,0,4'd0,1,8'd1,S_I);
    for (int k = 2; k <= 4; k++) begin
      add(0,1,0,16'h0000, 16'hF1F0,0,4'd0,1,8'(k),S_E);
      add(0,0,0,16'h0000, 16'hF1F0,0,4'd0,1,8'(k),S_I);
    end
    // reads serviced during ERR_HOLD, exit to ACTIVE with words left
    add(1,0,0,16'h1111, 16'hF1F0,0,4'd1,1,8'd4,S_A);
    add(1,0,0,16'h2222, 16'hF1F0,0,4'd2,1,8'd4,S_A);
    add(1,1,1,16'h3333, 16'h1111,1,4'd1,1,8'd5,S_E);
    add(1,0,0,16'h4444, 16'h1111,0,4'd1,1,8'd5,S_A);
    add(0,0,1,16'h0000, 16'h2222,1,4'd0,1,8'd5,S_I);
    // simultaneous write+read, and write+read on empty (no fall-through)
    add(1,0,0,16'h5555, 16'h2222,0,4'd1,1,8'd5,S_A);
    add(1,0,1,16'h6666, 16'h5555,1,4'd1,1,8'd5,S_A);
    add(0,0,1,16'h0000, 16'h6666,1,4'd0,1,8'd5,S_I);
    add(1,0,1,16'h7777, 16'h6666,0,4'd1,1,8'd5,S_A);
    add(0,0,1,16'h0000, 16'h7777,1,4'd0,1,8'd5,S_I);

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].e, vecs[i].r, vecs[i].din);
      check_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].dv, vecs[i].cnt,
                vecs[i].ovf, vecs[i].errc, vecs[i].st);
    end

    // mid-stream asynchronous reset
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 16'hC000 + 16'(k));
    chk("pre_reset count", 32'(fifo_count), 32'd5);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    check_all("pre_reset pop", 16'hC000, 1'b1, 4'd4, 1'b1, 8'd5, S_A);
    rd_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_all("async_reset", 16'h0000, 1'b0, 4'd0, 1'b0, 8'd0, S_I);
    @(posedge clk);
    #1 reset = 1'b1;
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    check_all("post_reset pop", 16'h0000, 1'b0, 4'd0, 1'b0, 8'd0, S_I);
    step(1'b1, 1'b0, 1'b0, 16'hD00D);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    check_all("post_reset fresh", 16'hD00D, 1'b1, 4'd0, 1'b0, 8'd0, S_I);

    // error counter saturation
    for (int k = 0; k < 255; k++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0000);
      if (k == 253) chk("err_count 254", 32'(err_count), 32'hFE);
      step(1'b0, 1'b0, 1'b0, 16'h0000);
    end
    chk("err_count 255", 32'(err_count), 32'hFF);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("err_count sat", 32'(err_count), 32'hFF);
    chk("sat state", 32'(state), 32'(S_E));
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_all("final", 16'hD00D, 1'b0, 4'd0, 1'b0, 8'hFF, S_I);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
